// File: rtl/cpu_types_pkg.sv
// Shared register-index and destination-tag types for the decode-to-writeback
// tag pipeline that feeds the forwarding unit.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef struct packed {
    logic     valid;
    regbits_t wsel;
    logic     regwrite;
    logic     memread;
  } dest_tag_t;

  localparam dest_tag_t TAG_BUBBLE = '0;

  // A tag only reports a register write for a real instruction targeting a non-zero register.
  function automatic dest_tag_t qualify_tag(input logic     valid,
                                            input regbits_t wsel,
                                            input logic     regwrite,
                                            input logic     memread);
    dest_tag_t t;
    t.valid    = valid;
    t.wsel     = wsel;
    t.regwrite = regwrite & valid & (wsel != 5'd0);
    t.memread  = memread & valid;
    return t;
  endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One pipeline stage's destination tag: freeze on hold, squash on bubble, otherwise load.
module fwd_stage_reg
  import cpu_types_pkg::*;
(
  input  logic      clk,
  input  logic      srst,
  input  logic      hold,
  input  logic      bubble,
  input  dest_tag_t d,
  output dest_tag_t q
);

  dest_tag_t tag_q, tag_d;

  always_comb begin
    tag_d = tag_q;
    if (!hold) begin
      tag_d = bubble ? TAG_BUBBLE : d;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      tag_q <= TAG_BUBBLE;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign q = tag_q;

endmodule

// File: rtl/fwd_source_pipe.sv
// Destination-tag pipeline (ID/EX, EX/MEM, MEM/WB) driving forwarding-unit sources,
// with load-use bubble insertion, data-cache freeze and branch-flush handling.
module fwd_source_pipe
  import cpu_types_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   id_valid,
  input  logic [4:0]             id_wsel,
  input  logic                   id_regwrite,
  input  logic                   id_memread,
  input  logic [4:0]             id_rsel1,
  input  logic [4:0]             id_rsel2,
  input  logic                   id_uses1,
  input  logic                   id_uses2,
  input  logic                   mem_wait,
  input  logic                   flush_idex,
  output logic [4:0]             wsel_memory,
  output logic [4:0]             wsel_writeback,
  output logic                   Reg_write_memory,
  output logic                   Reg_write_writeback,
  output logic [4:0]             ex_wsel,
  output logic                   load_use_stall,
  output logic                   pc_write_en,
  output logic [STALL_CNT_W-1:0] stall_count
);

  dest_tag_t id_tag;
  dest_tag_t idex_q, exmem_q, memwb_q;
  logic      hazard;
  logic      insert_bubble;

  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  assign id_tag = qualify_tag(id_valid, id_wsel, id_regwrite, id_memread);

  assign hazard = idex_q.valid & idex_q.memread & idex_q.regwrite & id_valid &
                  ((id_uses1 & (id_rsel1 == idex_q.wsel)) |
                   (id_uses2 & (id_rsel2 == idex_q.wsel)));

  // A freeze or a flush both make the stall unnecessary for this cycle.
  assign load_use_stall = hazard & ~flush_idex & ~mem_wait;
  assign pc_write_en    = ~load_use_stall & ~mem_wait;
  assign insert_bubble  = flush_idex | load_use_stall;

  fwd_stage_reg u_idex (
    .clk(CLK), .srst(RST), .hold(mem_wait), .bubble(insert_bubble),
    .d(id_tag), .q(idex_q)
  );

  fwd_stage_reg u_exmem (
    .clk(CLK), .srst(RST), .hold(mem_wait), .bubble(1'b0),
    .d(idex_q), .q(exmem_q)
  );

  fwd_stage_reg u_memwb (
    .clk(CLK), .srst(RST), .hold(mem_wait), .bubble(1'b0),
    .d(exmem_q), .q(memwb_q)
  );

  always_comb begin
    stall_count_d = stall_count_q;
    if (load_use_stall && (stall_count_q != {STALL_CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign ex_wsel             = idex_q.wsel;
  assign wsel_memory         = exmem_q.wsel;
  assign Reg_write_memory    = exmem_q.valid & exmem_q.regwrite;
  assign wsel_writeback      = memwb_q.wsel;
  assign Reg_write_writeback = memwb_q.valid & memwb_q.regwrite;
  assign stall_count         = stall_count_q;

  // Load flags past EX are carried for uniformity of the tag but not consumed.
  logic unused_tag_bits;
  assign unused_tag_bits = exmem_q.memread ^ memwb_q.memread;

endmodule

// File: tb/tb_fwd_source_pipe.sv
// Directed-vector bench: each row drives decode inputs and queues hand-computed outputs;
// a negedge monitor pops and compares them against two instances (16-bit and 2-bit counters).
module tb_fwd_source_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_regwrite, id_memread, id_uses1, id_uses2;
  logic [4:0] id_wsel, id_rsel1, id_rsel2;
  logic       mem_wait, flush_idex;

  logic [4:0]  wsel_memory, wsel_writeback, ex_wsel;
  logic        Reg_write_memory, Reg_write_writeback, load_use_stall, pc_write_en;
  logic [15:0] stall_count;

  logic [4:0] unused_wm, unused_ww, unused_exw;
  logic       unused_rwm, unused_rww, unused_lus, unused_pcwe;
  logic [1:0] stall_count_sat;

  always #5 clk = ~clk;

  fwd_source_pipe #(.STALL_CNT_W(16)) dut (
    .CLK(clk), .RST(rst),
    .id_valid(id_valid), .id_wsel(id_wsel), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_rsel1(id_rsel1), .id_rsel2(id_rsel2), .id_uses1(id_uses1), .id_uses2(id_uses2),
    .mem_wait(mem_wait), .flush_idex(flush_idex),
    .wsel_memory(wsel_memory), .wsel_writeback(wsel_writeback),
    .Reg_write_memory(Reg_write_memory), .Reg_write_writeback(Reg_write_writeback),
    .ex_wsel(ex_wsel), .load_use_stall(load_use_stall), .pc_write_en(pc_write_en),
    .stall_count(stall_count)
  );

  fwd_source_pipe #(.STALL_CNT_W(2)) dut_sat (
    .CLK(clk), .RST(rst),
    .id_valid(id_valid), .id_wsel(id_wsel), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_rsel1(id_rsel1), .id_rsel2(id_rsel2), .id_uses1(id_uses1), .id_uses2(id_uses2),
    .mem_wait(mem_wait), .flush_idex(flush_idex),
    .wsel_memory(unused_wm), .wsel_writeback(unused_ww),
    .Reg_write_memory(unused_rwm), .Reg_write_writeback(unused_rww),
    .ex_wsel(unused_exw), .load_use_stall(unused_lus), .pc_write_en(unused_pcwe),
    .stall_count(stall_count_sat)
  );

  typedef struct {
    int row;
    int exw, wm, rwm, ww, rww, lus, pcwe, cnt, cnts;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   row_no   = 0;

  task automatic chk(input string name, input int row, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL row %0d %s: got %0d expected %0d", row, name, act, req);
    end
  endtask

  // Monitor: outputs are compared at the falling edge, after the row's inputs have settled.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ex_wsel",             e.row, int'(ex_wsel),             e.exw);
      chk("wsel_memory",         e.row, int'(wsel_memory),         e.wm);
      chk("Reg_write_memory",    e.row, int'(Reg_write_memory),    e.rwm);
      chk("wsel_writeback",      e.row, int'(wsel_writeback),      e.ww);
      chk("Reg_write_writeback", e.row, int'(Reg_write_writeback), e.rww);
      chk("load_use_stall",      e.row, int'(load_use_stall),      e.lus);
      chk("pc_write_en",         e.row, int'(pc_write_en),         e.pcwe);
      chk("stall_count",         e.row, int'(stall_count),         e.cnt);
      chk("stall_count_sat",     e.row, int'(stall_count_sat),     e.cnts);
      $display("row %0d: exw=%0d wm=%0d/%0d ww=%0d/%0d lus=%0d pcwe=%0d cnt=%0d sat=%0d",
               e.row, ex_wsel, wsel_memory, Reg_write_memory, wsel_writeback,
               Reg_write_writeback, load_use_stall, pc_write_en, stall_count, stall_count_sat);
    end
  end

  // One cycle: drive inputs just after the rising edge, queue the expected outputs.
  task automatic step(input logic r, input logic v, input int w, input logic rw, input logic mr,
                      input int r1, input logic u1, input int r2, input logic u2,
                      input logic mw, input logic fl,
                      input int exw, input int wm, input int rwm, input int ww, input int rww,
                      input int lus, input int pcwe, input int cnt, input int cnts);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_wsel = w[4:0]; id_regwrite = rw; id_memread = mr;
    id_rsel1 = r1[4:0]; id_uses1 = u1; id_rsel2 = r2[4:0]; id_uses2 = u2;
    mem_wait = mw; flush_idex = fl;
    e.row = row_no; e.exw = exw; e.wm = wm; e.rwm = rwm; e.ww = ww; e.rww = rww;
    e.lus = lus; e.pcwe = pcwe; e.cnt = cnt; e.cnts = cnts;
    exp_q.push_back(e);
    row_no++;
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_wsel = 0; id_regwrite = 0; id_memread = 0;
    id_rsel1 = 0; id_rsel2 = 0; id_uses1 = 0; id_uses2 = 0; mem_wait = 0; flush_idex = 0;
    repeat (2) @(posedge clk);

    //   rst v  w rw mr r1 u1 r2 u2 mw fl | exw wm rwm ww rww lus pcwe cnt cnts
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0, 0);  // 0 reset state
    step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0, 0);  // 1 write r5
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   5, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 5, 1, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 5, 1, 0, 1, 0, 0);
    step(0, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0, 0);  // 5 load r8
    step(0, 1, 9, 1, 0, 8, 1, 0, 0, 0, 0,   8, 0, 0, 0, 0, 1, 0, 0, 0);  // 6 dependent: stall
    step(0, 1, 9, 1, 0, 8, 1, 0, 0, 0, 0,   0, 8, 1, 0, 0, 0, 1, 1, 1);  // 7 replay, no stall
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   9, 0, 0, 8, 1, 0, 1, 1, 1);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 9, 1, 0, 0, 0, 1, 1, 1);  // 9 write to r0
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 9, 1, 0, 1, 1, 1);
    step(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 1, 1);  // 11 r0 never reported
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 3, 1, 0, 0, 0, 0, 1, 1);  // 13 freeze x3
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 3, 1, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 3, 1, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 3, 1, 0, 0, 0, 1, 1, 1);  // 16 released
    step(0, 1, 4, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3, 1, 0, 1, 1, 1);  // 17 load r4
    step(0, 1, 6, 1, 0, 0, 0, 4, 1, 1, 0,   4, 0, 0, 0, 0, 0, 0, 1, 1);  // 18 hazard under freeze
    step(0, 1, 6, 1, 0, 0, 0, 4, 1, 0, 0,   4, 0, 0, 0, 0, 1, 0, 1, 1);  // 19 freeze drops: stall
    step(0, 1, 6, 1, 0, 0, 0, 4, 1, 0, 0,   0, 4, 1, 0, 0, 0, 1, 2, 2);
    step(0, 1, 7, 1, 1, 0, 0, 0, 0, 0, 0,   6, 0, 0, 4, 1, 0, 1, 2, 2);  // 21 load r7
    step(0, 1,10, 1, 0, 7, 1, 0, 0, 0, 1,   7, 6, 1, 0, 0, 0, 1, 2, 2);  // 22 hazard + flush
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 7, 1, 6, 1, 0, 1, 2, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 7, 1, 0, 1, 2, 2);
    step(0, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 2, 2);  // 25 stall #3
    step(0, 1, 0, 0, 0, 8, 1, 0, 0, 0, 0,   8, 0, 0, 0, 0, 1, 0, 2, 2);
    step(0, 1, 0, 0, 0, 8, 1, 0, 0, 0, 0,   0, 8, 1, 0, 0, 0, 1, 3, 3);
    step(0, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 8, 1, 0, 1, 3, 3);  // 28 stall #4
    step(0, 1, 0, 0, 0, 8, 1, 0, 0, 0, 0,   8, 0, 0, 0, 0, 1, 0, 3, 3);
    step(0, 1, 0, 0, 0, 8, 1, 0, 0, 0, 0,   0, 8, 1, 0, 0, 0, 1, 4, 3);  // 30 2-bit saturated
    step(0, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 8, 1, 0, 1, 4, 3);  // 31 stall #5
    step(0, 1, 0, 0, 0, 8, 1, 0, 0, 0, 0,   8, 0, 0, 0, 0, 1, 0, 4, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 8, 1, 0, 0, 0, 1, 5, 3);
    step(1, 1, 8, 1, 1, 0, 0, 0, 0, 1, 0,   0, 0, 0, 8, 1, 0, 0, 5, 3);  // 34 reset during freeze
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0, 0);  // 35 fully cleared

    begin : drain
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        checks++;
        failures++;
        $display("FAIL drain: got %0d pending rows expected 0", exp_q.size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
